mult_arbiter: RTL and testbench



---
 rtl/elliptic_curve_structs.sv | 37 +++
 rtl/mult_arbiter_if.sv | 24 ++
 rtl/multiplier.sv | 60 ++++++
 rtl/reg_256.sv | 17 +
 rtl/rr_pick.sv | 36 +++
 rtl/mult_arbiter.sv | 130 +++++++++++++
 tb/tb_mult_arbiter.sv | 290 +++++++++++++++++++++++++++++
 7 files changed

// File: rtl/elliptic_curve_structs.sv
// Shared curve types: modulus, scheduler states and the modular add
// used by the shared multiplier datapath.
package elliptic_curve_structs;

  typedef struct packed {
    logic [255:0] n;
  } curve_params_t;

  localparam curve_params_t params = '{
    n: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
  };

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LAUNCH,
    ARB_WAIT,
    ARB_RESP
  } mult_arb_state_t;

  typedef enum logic [1:0] {
    MUL_INIT,
    MUL_RUN,
    MUL_DONE
  } mul_state_t;

  // x + y mod n for x, y < n
  function automatic logic [255:0] mod_add(
    input logic [255:0] x,
    input logic [255:0] y
  );
    logic [256:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, params.n}) s = s - {1'b0, params.n};
    return s[255:0];
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bundle of the shared multiplier scheduler:
// per-requester levels/operands in, one-hot done + product out.
interface mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0][255:0] a_req;
  logic [NUM_REQ-1:0][255:0] b_req;
  logic [NUM_REQ-1:0]        done;
  logic [255:0]              product;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output req, a_req, b_req,
    input  done, product, busy, grant_id
  );

  modport slave (
    input  req, a_req, b_req,
    output done, product, busy, grant_id
  );
endinterface

// File: rtl/multiplier.sv
// Bit-serial a*b mod n: scans a LSB-first straight off the port,
// so a must stay stable until done. done holds until next Reset.
module multiplier
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         Reset,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] product,
  output logic         done
);

  mul_state_t   state_q, state_d;
  logic [255:0] acc_q, acc_d;
  logic [255:0] base_q, base_d;
  logic [7:0]   idx_q, idx_d;

  // add b*2^i into the accumulator for each set bit of a
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    idx_d   = idx_q;
    case (state_q)
      MUL_INIT: begin
        acc_d   = '0;
        base_d  = b;
        idx_d   = '0;
        state_d = MUL_RUN;
      end
      MUL_RUN: begin
        if (a[idx_q]) acc_d = mod_add(acc_q, base_q);
        base_d = mod_add(base_q, base_q);
        idx_d  = idx_q + 8'd1;
        if (idx_q == 8'd255) state_d = MUL_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= MUL_INIT;
      acc_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  assign product = acc_q;
  assign done    = (state_q == MUL_DONE);

endmodule

// File: rtl/reg_256.sv
// 256-bit register with synchronous clear and load enable.
// Holds operands and results around the shared multiplier.
module reg_256 (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [255:0] d,
  output logic [255:0] q
);

  // clear on reset, load when enabled
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req at or above ptr, wrapping.
// Shared by the multiplier, adder and inverter schedulers.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // scan N slots upward from ptr, keep the first hit
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
      idx = sum[ID_W-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin owner of the shared modular multiplier: latches the
// winner's operands, restarts the multiplier, returns the product.
module mult_arbiter
  import elliptic_curve_structs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           Reset,
  mult_arbiter_if.slave  bus
);

  mult_arb_state_t    state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;

  logic [255:0] sel_a, sel_b;
  logic [255:0] op_a_q, op_b_q, res_q;
  logic [255:0] mul_product;
  logic         op_en, res_en;
  logic         mul_rst, mul_reset, mul_done;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // AND-OR mux of the winner's operands
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = sel_a | bus.a_req[i];
        sel_b = sel_b | bus.b_req[i];
      end
    end
  end

  reg_256 u_op_a (
    .clk (clk), .rst (Reset), .en (op_en),
    .d   (sel_a), .q (op_a_q)
  );

  reg_256 u_op_b (
    .clk (clk), .rst (Reset), .en (op_en),
    .d   (sel_b), .q (op_b_q)
  );

  reg_256 u_res (
    .clk (clk), .rst (Reset), .en (res_en),
    .d   (mul_product), .q (res_q)
  );

  assign mul_reset = Reset | mul_rst;

  multiplier u_mul (
    .clk     (clk),
    .Reset   (mul_reset),
    .a       (op_a_q),
    .b       (op_b_q),
    .product (mul_product),
    .done    (mul_done)
  );

  // grant, restart the multiplier, wait, report
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    done_d  = '0;
    op_en   = 1'b0;
    res_en  = 1'b0;
    mul_rst = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          op_en   = 1'b1;
          gid_d   = pick_id;
          ptr_d   = (pick_id == ID_W'(NUM_REQ - 1))
                    ? '0 : pick_id + 1'b1;
          state_d = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        mul_rst = 1'b1;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mul_done) begin
          res_en        = 1'b1;
          done_d[gid_q] = 1'b1;
          state_d       = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.product  = (state_q == ARB_RESP) ? res_q : '0;
  assign bus.busy     = (state_q != ARB_IDLE);
  assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed vectors, multi-cycle corners and
// random traffic against a round-robin / a*b mod n reference.
module tb_mult_arbiter;
  import elliptic_curve_structs::*;

  localparam int NR = 4;
  localparam int IW = $clog2(NR);

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NUM_REQ(NR)) bus ();

  mult_arbiter #(.NUM_REQ(NR)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           id;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
  } vec_t;

  vec_t tbl[5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a,
                                          input logic [255:0] b);
    logic [511:0] p;
    p = 512'(a) * 512'(b);
    p = p % 512'(params.n);
    return p[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r % params.n;
  endfunction

  function automatic int rr_next(input logic [NR-1:0] pend, input int p);
    for (int i = 0; i < NR; i++)
      if (pend[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    if (!$onehot(v)) return -2;
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // waits for a done pulse; mdh = {mul_done two cycles before, one before}
  task automatic wait_done(output int who, output logic [255:0] prod,
                           output logic [1:0] mdh);
    logic p1, p2;
    bit   got;
    who  = -1;
    prod = '0;
    mdh  = 2'b11;
    got  = 1'b0;
    p1   = dut.mul_done;
    p2   = 1'b1;
    for (int c = 0; c < 2000 && !got; c++) begin
      tick;
      if (bus.done != '0) begin
        got  = 1'b1;
        who  = idx_of(bus.done);
        prod = bus.product;
        mdh  = {p2, p1};
      end else begin
        p2 = p1;
        p1 = dut.mul_done;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got none want pulse");
    end
  endtask

  task automatic pulse_reset;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
  endtask

  int           who;
  logic [255:0] prod;
  logic [1:0]   mdh;
  int           order[5];
  logic [NR-1:0]     pend;
  logic [NR-1:0][255:0] ma, mb;
  int           mptr, expw, issued, seen;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    bus.req   = '0;
    bus.a_req = '0;
    bus.b_req = '0;

    tbl[0] = '{0, 256'd2, 256'd3, 256'd6};
    tbl[1] = '{0, params.n - 256'd1, params.n - 256'd1, 256'd1};
    tbl[2] = '{0, 256'd0, params.n - 256'd1, 256'd0};
    tbl[3] = '{1, params.n - 256'd1, 256'd2, params.n - 256'd2};
    tbl[4] = '{2, 256'd1 << 128, 256'd1 << 128, 256'h1_000003D1};

    tick;
    tick;
    chk("rst_done", 256'(bus.done), '0);
    chk("rst_product", bus.product, '0);
    chk("rst_busy", 256'(bus.busy), '0);
    chk("rst_grant_id", 256'(bus.grant_id), '0);
    Reset = 1'b0;
    tick;

    // directed single-requester vectors
    for (int v = 0; v < 5; v++) begin
      bus.req[tbl[v].id]   = 1'b1;
      bus.a_req[tbl[v].id] = tbl[v].a;
      bus.b_req[tbl[v].id] = tbl[v].b;
      tick;
      chk($sformatf("vec%0d_busy", v), 256'(bus.busy), 256'd1);
      chk_i($sformatf("vec%0d_gid", v), int'(bus.grant_id), tbl[v].id);
      wait_done(who, prod, mdh);
      bus.req[tbl[v].id] = 1'b0;
      chk_i($sformatf("vec%0d_done_id", v), who, tbl[v].id);
      chk($sformatf("vec%0d_product", v), prod, tbl[v].p);
      chk($sformatf("vec%0d_done_after_mul_done", v), 256'(mdh), 256'd1);
      tick;
      chk($sformatf("vec%0d_busy_fall", v), 256'(bus.busy), '0);
      chk($sformatf("vec%0d_single_pulse", v), 256'(bus.done), '0);
    end

    // fairness with all requesters held high
    pulse_reset;
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < NR; k++) begin
      bus.a_req[k] = 256'(k + 1);
      bus.b_req[k] = 256'd5;
    end
    bus.req = '1;
    for (int i = 0; i < 5; i++) begin
      wait_done(who, prod, mdh);
      chk_i($sformatf("fair%0d_id", i), who, order[i]);
      chk($sformatf("fair%0d_product", i), prod,
          256'(5 * (order[i] + 1)));
    end
    bus.req = '0;
    tick;

    // operands changed after grant must not matter
    pulse_reset;
    bus.req[1]   = 1'b1;
    bus.a_req[1] = 256'd7;
    bus.b_req[1] = 256'd9;
    tick;
    bus.a_req[1] = rand256();
    bus.b_req[1] = rand256();
    wait_done(who, prod, mdh);
    bus.req[1] = 1'b0;
    chk_i("hold_id", who, 1);
    chk("hold_product", prod, 256'd63);
    tick;

    // reset mid-WAIT aborts silently and restarts ptr at 0
    bus.req[2]   = 1'b1;
    bus.a_req[2] = 256'd3;
    bus.b_req[2] = 256'd4;
    tick;
    repeat (100) tick;
    bus.req[2] = 1'b0;
    pulse_reset;
    chk("abort_busy", 256'(bus.busy), '0);
    chk("abort_done", 256'(bus.done), '0);
    seen = 0;
    repeat (300) begin
      tick;
      if (bus.done != '0) seen++;
    end
    chk_i("abort_no_done", seen, 0);
    bus.req[1]   = 1'b1;
    bus.a_req[1] = 256'd11;
    bus.b_req[1] = 256'd13;
    bus.req[3]   = 1'b1;
    bus.a_req[3] = 256'd17;
    bus.b_req[3] = 256'd19;
    tick;
    chk_i("fresh_gid", int'(bus.grant_id), 1);
    wait_done(who, prod, mdh);
    chk_i("fresh_id", who, 1);
    chk("fresh_product", prod, 256'd143);
    bus.req[1]   = 1'b0;
    bus.req[2]   = 1'b1;
    bus.a_req[2] = 256'd21;
    bus.b_req[2] = 256'd23;

    // requester 2 drops its request mid-operation
    tick;
    tick;
    chk_i("drop_gid", int'(bus.grant_id), 2);
    repeat (50) tick;
    bus.req[2] = 1'b0;
    wait_done(who, prod, mdh);
    chk_i("drop_id", who, 2);
    chk("drop_product", prod, 256'd483);
    wait_done(who, prod, mdh);
    chk_i("after_drop_id", who, 3);
    chk("after_drop_product", prod, 256'd323);
    bus.req[3] = 1'b0;
    tick;

    // random traffic against the reference model
    pulse_reset;
    mptr   = 0;
    issued = 0;
    pend   = NR'($urandom_range(1, (1 << NR) - 1));
    for (int k = 0; k < NR; k++) begin
      ma[k] = rand256();
      mb[k] = rand256();
      if ($urandom_range(0, 3) == 0) ma[k] = params.n - 256'd1;
      bus.a_req[k] = ma[k];
      bus.b_req[k] = mb[k];
    end
    bus.req = pend;
    for (int op = 0; op < 24 && pend != '0; op++) begin
      expw = rr_next(pend, mptr);
      wait_done(who, prod, mdh);
      chk_i($sformatf("rnd%0d_id", op), who, expw);
      chk($sformatf("rnd%0d_product", op), prod,
          mulmod(ma[expw], mb[expw]));
      pend[expw] = 1'b0;
      mptr = (expw + 1) % NR;
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && issued < 12 && $urandom_range(0, 2) == 0) begin
          ma[k] = rand256();
          mb[k] = rand256();
          bus.a_req[k] = ma[k];
          bus.b_req[k] = mb[k];
          pend[k] = 1'b1;
          issued++;
        end
      end
      bus.req = pend;
    end
    chk("rnd_all_served", 256'(pend), '0);
    bus.req = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
